patch_addr_gen: RTL

// - Raster-scans a 3x3 window over a single-channel IMG_W x IMG_H image held in image_mem.
// - Drives the nine pixel addresses and the load strobe of patch_data_latch, upstream of that latch.
// - Tells the downstream convolution/MAC stage when the latched patch is valid, using a valid/ready handshake.
// - Emits one pulse after the last output position has been consumed.

---
 rtl/cnn_pkg.sv | 30 +++
 rtl/patch_addr_gen_window_counter.sv | 71 +++++++
 rtl/patch_addr_gen.sv | 125 ++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared constants for the patch address generator: image defaults,
// kernel size and the sequencing FSM encoding.
package cnn_pkg;

  localparam int IMG_W_DEF  = 28;
  localparam int IMG_H_DEF  = 28;
  localparam int STRIDE_DEF = 1;
  localparam int ADDR_W_DEF = 10;
  localparam int K          = 3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_VALID = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = S_IDLE,
    ADDR  = S_ADDR,
    LOAD  = S_LOAD,
    VALID = S_VALID,
    FIN   = S_FIN
  } state_t;

  // Offset of window tap k from the window's top-left pixel.
  function automatic int tap_offset(input int k, input int img_w);
    return (k / K) * img_w + (k % K);
  endfunction

endpackage

// File: rtl/patch_addr_gen_window_counter.sv
// Output-map position tracker. Keeps row/col, the window base address and
// the base of the current window row, using adds only.
module window_counter
  import cnn_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int STRIDE = STRIDE_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int OUT_W  = (IMG_W_DEF - K) / STRIDE_DEF + 1,
  parameter int OUT_H  = (IMG_H_DEF - K) / STRIDE_DEF + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  output logic [7:0]        row,
  output logic [7:0]        col,
  output logic [ADDR_W-1:0] base_nxt,
  output logic              last
);

  localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(STRIDE * IMG_W);

  logic [ADDR_W-1:0] base, row_base, row_base_nxt;
  logic [7:0]        row_nxt, col_nxt;
  logic              col_last;

  assign col_last = (col == 8'(OUT_W - 1));
  assign last     = col_last && (row == 8'(OUT_H - 1));

  // Next position: clear restarts at the origin, advance steps one window.
  always_comb begin
    row_nxt      = row;
    col_nxt      = col;
    row_base_nxt = row_base;
    base_nxt     = base;
    if (clear) begin
      row_nxt      = 8'd0;
      col_nxt      = 8'd0;
      row_base_nxt = '0;
      base_nxt     = '0;
    end else if (advance) begin
      if (col_last) begin
        row_nxt      = row + 8'd1;
        col_nxt      = 8'd0;
        row_base_nxt = row_base + ROW_STEP;
        base_nxt     = row_base + ROW_STEP;
      end else begin
        col_nxt  = col + 8'd1;
        base_nxt = base + COL_STEP;
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      row      <= 8'd0;
      col      <= 8'd0;
      row_base <= '0;
      base     <= '0;
    end else begin
      row      <= row_nxt;
      col      <= col_nxt;
      row_base <= row_base_nxt;
      base     <= base_nxt;
    end
  end

endmodule

// File: rtl/patch_addr_gen.sv
// 3x3 window raster scanner: drives the nine tap addresses and the latch
// strobe, then offers the latched patch downstream with valid/ready.
//
//  state | meaning
//  IDLE  | waiting for start
//  ADDR  | tap addresses stable, image memory samples them this cycle
//  LOAD  | memory data present, latch strobe high
//  VALID | patch held, waiting for patch_ready
//  FIN   | one-cycle done pulse after the last accepted patch
module patch_addr_gen
  import cnn_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int STRIDE = STRIDE_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              patch_ready,
  output logic [ADDR_W-1:0] pixel_addr0,
  output logic [ADDR_W-1:0] pixel_addr1,
  output logic [ADDR_W-1:0] pixel_addr2,
  output logic [ADDR_W-1:0] pixel_addr3,
  output logic [ADDR_W-1:0] pixel_addr4,
  output logic [ADDR_W-1:0] pixel_addr5,
  output logic [ADDR_W-1:0] pixel_addr6,
  output logic [ADDR_W-1:0] pixel_addr7,
  output logic [ADDR_W-1:0] pixel_addr8,
  output logic              load,
  output logic              patch_valid,
  output logic [7:0]        out_row,
  output logic [7:0]        out_col,
  output logic              busy,
  output logic              done
);

  localparam int OUT_W = (IMG_W - K) / STRIDE + 1;
  localparam int OUT_H = (IMG_H - K) / STRIDE + 1;

  state_t            state_q, state_d;
  logic              scan_start, step, last;
  logic [ADDR_W-1:0] base_nxt;
  logic [ADDR_W-1:0] addr_q [K*K];

  // The counter only steps between patches, never on the final accept,
  // so out_row/out_col stay on the last patch through FIN.
  window_counter #(
    .IMG_W (IMG_W),
    .STRIDE(STRIDE),
    .ADDR_W(ADDR_W),
    .OUT_W (OUT_W),
    .OUT_H (OUT_H)
  ) u_window_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (scan_start),
    .advance (step),
    .row     (out_row),
    .col     (out_col),
    .base_nxt(base_nxt),
    .last    (last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and position control strobes.
  always_comb begin
    state_d    = state_q;
    scan_start = 1'b0;
    step       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          scan_start = 1'b1;
          state_d    = ADDR;
        end
      end
      ADDR:  state_d = LOAD;
      LOAD:  state_d = VALID;
      VALID: begin
        if (patch_ready) begin
          if (last) begin
            state_d = FIN;
          end else begin
            step    = 1'b1;
            state_d = ADDR;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Tap addresses, reloaded only when entering ADDR.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < K*K; k++) addr_q[k] <= '0;
    end else if (scan_start || step) begin
      for (int k = 0; k < K*K; k++) addr_q[k] <= base_nxt + ADDR_W'(tap_offset(k, IMG_W));
    end
  end

  assign pixel_addr0 = addr_q[0];
  assign pixel_addr1 = addr_q[1];
  assign pixel_addr2 = addr_q[2];
  assign pixel_addr3 = addr_q[3];
  assign pixel_addr4 = addr_q[4];
  assign pixel_addr5 = addr_q[5];
  assign pixel_addr6 = addr_q[6];
  assign pixel_addr7 = addr_q[7];
  assign pixel_addr8 = addr_q[8];

  assign load        = (state_q == LOAD);
  assign patch_valid = (state_q == VALID);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FIN);

endmodule
